// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the load/store controller: access sizes, FSM states, byte-lane helpers.
// Pure declarations; no logic.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return LANE_MASK_BYTE;
            SZ_HALF: return LANE_MASK_HALF;
            default: return LANE_MASK_WORD;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
`timescale 1ns/1ps
// Request/response bus between the datapath FSM and the load/store controller, plus the
// controller's view of the word-addressed Memory port.
interface mem_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport master (
        output req, wr, size, sext, addr, wdata, mem_rd,
        input  ready, done, err, rdata, mem_addr, mem_wd, mem_we
    );

    modport slave (
        input  req, wr, size, sext, addr, wdata, mem_rd,
        output ready, done, err, rdata, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/byte_lane_unit.sv
`timescale 1ns/1ps
// Combinational lane steering: extracts/extends a byte or half from a word, and merges
// store data into a word. Zero latency, no handshake.
module byte_lane_unit
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [1:0]  lane_lo;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] raw;
    logic [31:0] sign_fill;

    always_comb begin
        // Big-endian puts offset 0 at the top, so the lane's low byte index counts down.
        if (BIG_ENDIAN) begin
            lane_lo = 2'(3'd4 - size_bytes(size) - {1'b0, offset});
        end else begin
            lane_lo = offset;
        end
        shamt     = {lane_lo, 3'b000};
        mask      = lane_mask(size);
        raw       = (word >> shamt) & mask;
        sign_fill = '0;
        if (sext) begin
            case (size)
                SZ_BYTE: if (raw[7])  sign_fill = ~mask;
                SZ_HALF: if (raw[15]) sign_fill = ~mask;
                default: sign_fill = '0;
            endcase
        end
        load_val   = raw | sign_fill;
        store_word = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// Load/store controller in front of a combinational-read, posedge-write word Memory.
// Loads/word stores finish in 2 cycles, sub-word stores (read-modify-write) in 3; req ignored unless ready.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mem_access_ctrl_if.slave bus
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic        req_bad;
    logic        req_sub_store;
    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic [31:0] store_word;

    logic        ready_o, done_o, err_o, mem_we_o;
    logic [31:0] mem_wd_o;

    always_comb begin
        req_bad = (bus.size == SZ_RSVD)
                | ((bus.size == SZ_HALF) && bus.addr[0])
                | ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00))
                | ({1'b0, bus.addr} >= ADDR_LIMIT);
        req_sub_store = bus.wr && (bus.size != SZ_WORD);
    end

    // The merge path works on the buffered word; the load path on live Memory data.
    assign lane_word = (state_q == ST_RMW_WR) ? buf_q : bus.mem_rd;

    byte_lane_unit #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .word       (lane_word),
        .offset     (off_q),
        .size       (size_q),
        .sext       (sext_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (req_bad)            state_d = ST_RESP;
                    else if (req_sub_store) state_d = ST_RMW_RD;
                    else                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so an async reset kills mem_we immediately.
    always_comb begin
        ready_o  = 1'b0;
        done_o   = 1'b0;
        err_o    = 1'b0;
        mem_we_o = 1'b0;
        mem_wd_o = '0;
        case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_ACCESS: begin
                if (wr_q) begin
                    mem_we_o = 1'b1;
                    mem_wd_o = wdata_q;
                end
            end
            ST_RMW_WR: begin
                mem_we_o = 1'b1;
                mem_wd_o = store_word;
            end
            ST_RESP: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ready_o = 1'b0;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        size_d     = size_q;
        sext_d     = sext_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        buf_d      = buf_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    wr_d    = bus.wr;
                    size_d  = bus.size;
                    sext_d  = bus.sext;
                    off_d   = bus.addr[1:0];
                    wdata_d = bus.wdata;
                    err_d   = req_bad;
                    if (!req_bad) mem_addr_d = {bus.addr[31:2], 2'b00};
                end
            end
            ST_ACCESS: if (!wr_q) rdata_d = load_val;
            ST_RMW_RD: buf_d = bus.mem_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            sext_q     <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            buf_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            wr_q       <= wr_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            buf_q      <= buf_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.ready    = ready_o;
    assign bus.done     = done_o;
    assign bus.err      = err_o;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_o;
    assign bus.mem_we   = mem_we_o;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_access_ctrl: directed test-plan cases, mid-access resets, then random traffic
// checked every cycle against a byte-array reference model of the Memory.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .MEM_WORDS (MW),
        .BIG_ENDIAN(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];
    logic        preload;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'h1122_3344;
        if (i == 32'h41) return 32'h8899_AABB;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.mem_rd = mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wd;
        end
    end

    int errors = 0;
    int checks = 0;

    logic        check_en = 1'b0;
    logic        exp_ready, exp_done, exp_err, exp_we, wd_chk;
    logic [31:0] exp_rdata, exp_maddr, exp_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready", 32'(bus.ready), 32'(exp_ready));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("err", 32'(bus.err), 32'(exp_err));
            chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
            chk("rdata", bus.rdata, exp_rdata);
            chk("mem_addr", bus.mem_addr, exp_maddr);
            if (wd_chk) chk("mem_wd", bus.mem_wd, exp_wd);
        end
    end

    // Reference model: Memory as four bytes per word, offset 0 most significant.
    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_reject(input logic [1:0] s, input logic [31:0] a);
        int n;
        n = nbytes(s);
        if (n == 0) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        if (a >= 32'(MW * 4)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int n,
                                             input logic sx);
        logic [7:0]  b [4];
        logic [31:0] v;
        for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(b[off+i]);
        if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int off, input int n,
                                              input logic [31:0] d);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = w[31-8*k -: 8];
        for (int i = 0; i < n; i++) b[off+i] = 8'(d >> (8 * (n - 1 - i)));
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic set_idle();
        exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
        exp_we = 1'b0; exp_wd = '0; wd_chk = 1'b1;
    endtask

    task automatic set_busy();
        exp_ready = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic set_resp(input logic e);
        exp_ready = 1'b0; exp_done = 1'b1; exp_err = e;
        exp_we = 1'b0; exp_wd = '0; wd_chk = 1'b1;
    endtask

    // Advance one edge; while busy the request pins carry junk that must be ignored.
    task automatic step();
        @(posedge clk);
        #2;
        bus.req   = 1'($urandom);
        bus.wr    = 1'($urandom);
        bus.size  = 2'($urandom);
        bus.sext  = 1'($urandom);
        bus.addr  = $urandom;
        bus.wdata = $urandom;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #2;
        bus.req = 1'b0;
        set_idle();
    endtask

    task automatic do_req(input logic w, input logic [1:0] s, input logic sx,
                          input logic [31:0] a, input logic [31:0] d);
        int n, off, widx;
        n    = nbytes(s);
        off  = int'(a[1:0]);
        widx = int'(a[11:2]);
        bus.req = 1'b1; bus.wr = w; bus.size = s; bus.sext = sx; bus.addr = a; bus.wdata = d;
        step();
        if (ref_reject(s, a)) begin
            set_resp(1'b1);
        end else begin
            exp_maddr = {a[31:2], 2'b00};
            set_busy();
            if (!w) begin
                exp_we = 1'b0; wd_chk = 1'b0;
                step();
                exp_rdata = ref_load(ref_mem[widx], off, n, sx);
            end else if (n == 4) begin
                exp_we = 1'b1; exp_wd = d; wd_chk = 1'b1;
                step();
                ref_mem[widx] = d;
            end else begin
                exp_we = 1'b0; wd_chk = 1'b0;
                step();
                exp_we = 1'b1; exp_wd = ref_store(ref_mem[widx], off, n, d); wd_chk = 1'b1;
                step();
                ref_mem[widx] = exp_wd;
            end
            set_resp(1'b0);
        end
        step();
        bus.req = 1'b0;
        set_idle();
        chk("mem_word", mem[widx], ref_mem[widx]);
    endtask

    task automatic reset_mid(input int phase);
        bus.req = 1'b1; bus.wr = 1'b1; bus.size = SZ_BYTE; bus.sext = 1'b0;
        bus.addr = 32'h101; bus.wdata = 32'h77;
        step();
        exp_maddr = 32'h100;
        set_busy();
        exp_we = 1'b0; wd_chk = 1'b0;
        if (phase == 1) begin
            step();
            exp_we = 1'b1; exp_wd = ref_store(ref_mem[32'h40], 1, 1, 32'h77); wd_chk = 1'b1;
            #1 chk("rmw_we_pre", 32'(bus.mem_we), 32'd1);
        end else begin
            #1;
        end
        rst_n = 1'b0;
        bus.req = 1'b0;
        set_idle();
        exp_rdata = '0;
        exp_maddr = '0;
        #1;
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle_cycle();
        chk("rst_mem", mem[32'h40], 32'h11EE_5566);
    endtask

    initial begin
        int bad;
        logic [31:0] a;
        int r;
        rst_n = 1'b0;
        preload = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = SZ_WORD; bus.sext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
        #1;
        chk("rst0_ready", 32'(bus.ready), 32'd1);
        chk("rst0_done", 32'(bus.done), 32'd0);
        chk("rst0_err", 32'(bus.err), 32'd0);
        chk("rst0_rdata", bus.rdata, 32'd0);
        chk("rst0_we", 32'(bus.mem_we), 32'd0);
        chk("rst0_maddr", bus.mem_addr, 32'd0);
        chk("rst0_wd", bus.mem_wd, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        exp_rdata = '0;
        exp_maddr = '0;
        idle_cycle();
        check_en = 1'b1;

        do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        chk("lw", bus.rdata, 32'h1122_3344);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h104, 32'h0);
        chk("lb", bus.rdata, 32'hFFFF_FF88);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h105, 32'h0);
        chk("lbu", bus.rdata, 32'h0000_0099);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h106, 32'h0);
        chk("lh", bus.rdata, 32'hFFFF_AABB);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h104, 32'h0);
        chk("lhu", bus.rdata, 32'h0000_8899);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h0000_00EE);
        chk("sb", mem[32'h40], 32'h11EE_3344);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0000_5566);
        chk("sh", mem[32'h40], 32'h11EE_5566);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h103, 32'h0);
        do_req(1'b0, SZ_RSVD, 1'b0, 32'h100, 32'h0);
        chk("rej_rdata", bus.rdata, 32'h0000_8899);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h1234_5678);
        chk("oor_mem0", mem[0], init_word(0));
        do_req(1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'hDEAD_BEEF);
        chk("sw_top", mem[1023], 32'hDEAD_BEEF);

        reset_mid(0);
        reset_mid(1);

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 7));
            else if (r == 1) a = 32'hFFC + 32'($urandom_range(0, 3));
            else if (r == 2) a = $urandom;
            else             a = 32'h200 + 32'($urandom_range(0, 31));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        bad = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
